// File: rtl/alu_result_stage_if.sv
// Valid/ready bundle between the ALU result mux, this stage and its consumer.
interface alu_result_stage_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic [2:0]   in_op;
  logic         in_carry;
  logic         in_overflow;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [2:0]   out_op;
  logic         out_zero;
  logic         out_negative;
  logic         out_carry;
  logic         out_overflow;

  modport master (
    output in_valid, in_result, in_op, in_carry, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, out_negative,
           out_carry, out_overflow
  );

  modport slave (
    input  in_valid, in_result, in_op, in_carry, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, out_negative,
           out_carry, out_overflow
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag generation, 2-entry skid buffer,
// sticky overflow and delivered-result counter.
module alu_result_stage #(
  parameter int         N      = 32,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SUB = 3'b110,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_stage_if.slave bus,
  input  logic             sticky_clr,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] result_count
);

  typedef struct packed {
    logic [N-1:0] result;
    logic [2:0]   op;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             arith;

  always_comb begin
    arith           = (bus.in_op == OP_ADD) || (bus.in_op == OP_SUB);
    in_d            = '0;
    in_d.result     = bus.in_result;
    in_d.op         = bus.in_op;
    in_d.zero       = (bus.in_result == '0);
    in_d.negative   = bus.in_result[N-1];
    in_d.carry      = arith & bus.in_carry;
    in_d.overflow   = arith & bus.in_overflow;
  end

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q      <= in_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_d;
          end else if (in_xfer) begin
            skid_q     <= in_d;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase

      // A delivered overflow beats a concurrent clear.
      if (out_xfer && main_q.overflow)
        sticky_q <= 1'b1;
      else if (sticky_clr)
        sticky_q <= 1'b0;

      if (out_xfer)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = main_q.result;
  assign bus.out_op       = main_q.op;
  assign bus.out_zero     = main_q.zero;
  assign bus.out_negative = main_q.negative;
  assign bus.out_carry    = main_q.carry;
  assign bus.out_overflow = main_q.overflow;
  assign sticky_ovf       = sticky_q;
  assign result_count     = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; inputs driven and outputs checked on negedge.
module tb_alu_result_stage;
  localparam int         N      = 32;
  localparam int         CNT_W  = 16;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  logic             clk = 1'b0;
  logic             rst;
  logic             sticky_clr;
  logic             sticky_ovf;
  logic [CNT_W-1:0] result_count;
  int               checks = 0;
  int               errors = 0;
  int               xfers;
  logic [N-1:0]     exp_val;

  alu_result_stage_if #(.N(N)) bus ();

  alu_result_stage #(
    .N(N), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sticky_clr(sticky_clr),
    .sticky_ovf(sticky_ovf),
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [N-1:0] r, input logic [2:0] op,
                       input logic c, input logic o);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_op       = op;
    bus.in_carry    = c;
    bus.in_overflow = o;
  endtask

  initial begin
    rst = 1'b1;
    sticky_clr = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);

    // Reset and single capture
    step();
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_count", result_count, 0);
    chk("rst_result", bus.out_result, 0);
    drive(1'b1, 32'h0000_0000, OP_ADD, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    chk("cap_out_valid", bus.out_valid, 1);
    chk("cap_zero", bus.out_zero, 1);
    chk("cap_carry", bus.out_carry, 1);
    chk("cap_negative", bus.out_negative, 0);
    chk("cap_op", bus.out_op, OP_ADD);
    step();
    chk("cap_drained", bus.out_valid, 0);
    chk("cap_count", result_count, 1);

    // Non-arithmetic op masks carry/overflow
    drive(1'b1, 32'h8000_0000, 3'b000, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    chk("mask_negative", bus.out_negative, 1);
    chk("mask_carry", bus.out_carry, 0);
    chk("mask_overflow", bus.out_overflow, 0);
    chk("mask_zero", bus.out_zero, 0);
    step();
    chk("mask_sticky", sticky_ovf, 0);
    chk("mask_count", result_count, 2);

    // Backpressure into the skid register
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1, OP_ADD, 1'b0, 1'b0);
    step();
    chk("bp_ready_after_1", bus.in_ready, 1);
    drive(1'b1, 32'h2, OP_ADD, 1'b0, 1'b0);
    step();
    chk("bp_ready_after_2", bus.in_ready, 0);
    chk("bp_head_1", bus.out_result, 32'h1);
    drive(1'b1, 32'h3, OP_ADD, 1'b0, 1'b0);
    step();
    chk("bp_still_full", bus.in_ready, 0);
    chk("bp_stable", bus.out_result, 32'h1);
    bus.out_ready = 1'b1;
    step();
    chk("bp_order_2", bus.out_result, 32'h2);
    chk("bp_ready_again", bus.in_ready, 1);
    step();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    chk("bp_order_3", bus.out_result, 32'h3);
    chk("bp_valid_3", bus.out_valid, 1);
    step();
    chk("bp_empty", bus.out_valid, 0);
    chk("bp_count", result_count, 5);

    // Full throughput after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    xfers = 0;
    exp_val = 32'h1;
    for (int k = 0; k <= 100; k++) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("tp_data", bus.out_result, exp_val);
        exp_val = exp_val + 1;
        xfers++;
      end
      if (k < 100) drive(1'b1, N'(k + 1), OP_ADD, 1'b0, 1'b0);
      else         drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
      step();
    end
    chk("tp_xfers", xfers, 100);
    chk("tp_count", result_count, 100);
    chk("tp_empty", bus.out_valid, 0);

    // Sticky overflow: set wins over a simultaneous clear
    drive(1'b1, 32'h5, OP_SUB, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    chk("st_out_ovf", bus.out_overflow, 1);
    chk("st_pre", sticky_ovf, 0);
    step();
    chk("st_set", sticky_ovf, 1);
    drive(1'b1, 32'h6, OP_SUB, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("st_set_wins", sticky_ovf, 1);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("st_cleared", sticky_ovf, 0);

    // Reset while FULL discards both entries
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, OP_ADD, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, OP_ADD, 1'b0, 1'b0);
    step();
    chk("mr_full", bus.in_ready, 0);
    rst = 1'b1;
    drive(1'b1, 32'hC, OP_ADD, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_in_ready", bus.in_ready, 1);
    chk("mr_count", result_count, 0);
    chk("mr_result", bus.out_result, 0);
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hD, OP_ADD, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    chk("mr_latency", bus.out_valid, 1);
    chk("mr_data", bus.out_result, 32'hD);
    step();
    chk("mr_no_stale", bus.out_valid, 0);
    chk("mr_count_after", result_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU's 8:1 result-select mux.
- Captures the selected result together with its op select and raw adder carry/overflow, computes status flags, and presents them on a valid/ready interface.
- A 2-entry skid buffer lets the ALU keep issuing for one cycle after the consumer stalls, without losing data.
- Also keeps a sticky overflow flag and a count of delivered results for debug readout.

Parameters:
- N, 32, datapath width of the result.
- OP_ADD, 3'b010, op select code for add; carry/overflow are valid only for this code and OP_SUB.
- OP_SUB, 3'b110, op select code for subtract.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_result  input  N  mux output (selected ALU result).
- in_op  input  3  mux select that produced in_result.
- in_carry  input  1  raw adder carry-out.
- in_overflow  input  1  raw adder signed overflow.
- out_valid  output  1  out_* fields hold a valid result.
- out_ready  input  1  downstream accepts this cycle.
- out_result  output  N  registered result.
- out_op  output  3  registered op select.
- out_zero  output  1  out_result == 0.
- out_negative  output  1  out_result[N-1].
- out_carry  output  1  carry; 0 unless out_op is OP_ADD or OP_SUB.
- out_overflow  output  1  overflow; 0 unless out_op is OP_ADD or OP_SUB.
- sticky_ovf  output  1  set by any delivered result with out_overflow=1.
- sticky_clr  input  1  clears sticky_ovf.
- result_count  output  CNT_W  number of delivered results; wraps at 2^CNT_W.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* fields stay stable while out_valid && !out_ready.
- Flags:
  - Flags are computed at capture from in_* and stored alongside the result.
  - Carry and overflow are masked to 0 when in_op is not OP_ADD or OP_SUB.
- Storage and state machine:
  - Storage is a main register (drives out_*) and a skid register.
  - States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
  - EMPTY: in xfer -> ONE (main <- in).
  - ONE:
    - in xfer && out xfer -> ONE (main <- in).
    - in xfer && !out xfer -> FULL (skid <- in).
    - out xfer only -> EMPTY.
  - FULL: in_ready=0; out xfer -> ONE (main <- skid).
- Handshake outputs:
  - in_ready is registered: 1 in EMPTY or ONE, 0 in FULL. It does not depend combinationally on out_ready.
  - out_valid is 1 in ONE and FULL.
- Latency: 1 cycle from input transfer to out_valid when the stage was EMPTY. Throughput is 1 result/cycle while out_ready is held high.
- Ordering: strict FIFO; skid content is always older than any new input.
- Sticky overflow:
  - Set on an output transfer whose out_overflow=1.
  - sticky_clr clears it.
  - Simultaneous set and clear -> set wins (the flag reads 1 next cycle).
- result_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset (synchronous, takes precedence over all other inputs, including mid-transfer): state EMPTY, out_valid=0, in_ready=1, all out_* fields 0, sticky_ovf=0, result_count=0. Any buffered entries are discarded. An in_valid pulse in the reset cycle is not captured.
- X-safety: out_* fields update only on a load. in_* are not sampled when in_valid=0.

Test Plan:
- Reset, single capture: rst 1 cycle; in_result=0x0000_0000, in_op=OP_ADD, in_carry=1, in_valid 1 cycle, out_ready=1. Required: out_valid on the next cycle; out_zero=1, out_carry=1; result_count=1 after the transfer.
- Non-arith mask: in_op=3'b000, in_result=0x8000_0000, in_carry=1, in_overflow=1. Required: out_negative=1, out_carry=0, out_overflow=0, sticky_ovf stays 0.
- Backpressure/skid: stream 0x1,0x2,0x3 on consecutive cycles with out_ready=0. Required:
  - 0x1 and 0x2 accepted; in_ready=0 from the cycle after 0x2's capture; 0x3 held by upstream.
  - With out_ready=1: 0x1, 0x2, 0x3 appear in order, no loss or duplication.
- Full throughput: 100 back-to-back results, out_ready=1. Required: 100 transfers in 101 cycles; result_count=100.
- Sticky: deliver OP_SUB with in_overflow=1, then assert sticky_clr in the same cycle as a second overflow transfer. Required: sticky_ovf=1; a later sticky_clr alone clears it to 0.
- Reset mid-operation: FULL state, then rst. Required: next cycle out_valid=0, in_ready=1, result_count=0; a new input after reset appears with 1-cycle latency.
